// File: rtl/guess_generator_if.sv
// Word handshake between the MD5 controller (master) and a guess generator (slave).
// The controller drives run control and the ready request; the generator returns the word.
interface guess_generator_if;
  logic         enable;
  logic [0:7]   start_position;
  logic [2:0]   increment;
  logic         next_req;
  logic [0:127] guess;
  logic         guess_valid;
  logic [0:7]   num_bits;
  logic         exhausted;

  modport master (
    output enable, start_position, increment, next_req,
    input  guess, guess_valid, num_bits, exhausted
  );

  modport slave (
    input  enable, start_position, increment, next_req,
    output guess, guess_valid, num_bits, exhausted
  );
endinterface

// File: rtl/guess_generator.sv
// Strided, length-increasing odometer that emits candidate passwords one per transfer.
// d[0] is the rightmost character; a carry out of the top digit grows the word by one.
module guess_generator #(
  parameter int unsigned MAX_CHARS    = 8,
  parameter int unsigned CHARSET_SIZE = 26,
  parameter logic [7:0]  FIRST_CHAR   = 8'h61
) (
  input  logic             clock,
  input  logic             reset,
  guess_generator_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, PRESENT, ADVANCE, DONE} state_t;

  state_t       r_state;
  logic [7:0]   r_digit [MAX_CHARS];
  logic [7:0]   r_start;
  logic [2:0]   r_inc;
  logic [4:0]   r_len;
  logic [0:127] r_guess;
  logic         r_valid;
  logic [0:7]   r_num_bits;
  logic         r_exhausted;

  logic [7:0]   w_start;
  logic [2:0]   w_inc;
  logic [7:0]   w_adv [MAX_CHARS];
  logic [8:0]   w_sum;
  logic         w_carry;

  function automatic logic [0:127] f_word(input logic [7:0] d [MAX_CHARS], input logic [4:0] len);
    logic [0:127] w;
    w = '0;
    for (int unsigned j = 0; j < MAX_CHARS; j++)
      if (j < 32'(len)) w[120-8*j +: 8] = FIRST_CHAR + d[j];
    return w;
  endfunction

  // Fresh word of a given length: d[0]=start, every higher digit at value 0.
  function automatic logic [0:127] f_fresh(input logic [7:0] start, input logic [4:0] len);
    logic [0:127] w;
    w = '0;
    for (int unsigned j = 0; j < MAX_CHARS; j++)
      if (j < 32'(len)) w[120-8*j +: 8] = (j == 0) ? FIRST_CHAR + start : FIRST_CHAR;
    return w;
  endfunction

  always_comb begin
    w_start = ({1'b0, bus.start_position} < 9'(CHARSET_SIZE)) ? bus.start_position : '0;
    w_inc   = (bus.increment == 3'd0) ? 3'd1 : bus.increment;
  end

  always_comb begin
    for (int unsigned j = 0; j < MAX_CHARS; j++) w_adv[j] = r_digit[j];
    w_sum   = {1'b0, r_digit[0]} + {6'b0, r_inc};
    w_carry = 1'b0;
    if (w_sum >= 9'(CHARSET_SIZE)) begin
      w_adv[0] = 8'(w_sum - 9'(CHARSET_SIZE));
      w_carry  = 1'b1;
    end else begin
      w_adv[0] = w_sum[7:0];
    end
    // Carry ripples only through the active digits; w_carry ends as carry out of d[L-1].
    for (int unsigned j = 1; j < MAX_CHARS; j++) begin
      if (w_carry && (j < 32'(r_len))) begin
        if (({1'b0, r_digit[j]} + 9'd1) >= 9'(CHARSET_SIZE)) begin
          w_adv[j] = '0;
        end else begin
          w_adv[j] = r_digit[j] + 8'd1;
          w_carry  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      for (int unsigned j = 0; j < MAX_CHARS; j++) r_digit[j] <= '0;
      r_start     <= '0;
      r_inc       <= '0;
      r_len       <= '0;
      r_guess     <= '0;
      r_valid     <= 1'b0;
      r_num_bits  <= '0;
      r_exhausted <= 1'b0;
    end else if (!bus.enable) begin
      r_state     <= IDLE;
      r_guess     <= '0;
      r_valid     <= 1'b0;
      r_num_bits  <= '0;
      r_exhausted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= LOAD;
        LOAD: begin
          r_start <= w_start;
          r_inc   <= w_inc;
          r_len   <= 5'd1;
          for (int unsigned j = 0; j < MAX_CHARS; j++) r_digit[j] <= (j == 0) ? w_start : '0;
          r_guess    <= f_fresh(w_start, 5'd1);
          r_num_bits <= 8'd8;
          r_valid    <= 1'b1;
          r_state    <= PRESENT;
        end
        PRESENT: begin
          if (bus.next_req) begin
            r_valid <= 1'b0;
            r_state <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (!w_carry) begin
            for (int unsigned j = 0; j < MAX_CHARS; j++) r_digit[j] <= w_adv[j];
            r_guess <= f_word(w_adv, r_len);
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end else if (32'(r_len) < MAX_CHARS) begin
            r_len <= r_len + 5'd1;
            for (int unsigned j = 0; j < MAX_CHARS; j++) r_digit[j] <= (j == 0) ? r_start : '0;
            r_guess    <= f_fresh(r_start, r_len + 5'd1);
            r_num_bits <= {r_len + 5'd1, 3'b000};
            r_valid    <= 1'b1;
            r_state    <= PRESENT;
          end else begin
            r_exhausted <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.guess       = r_guess;
  assign bus.guess_valid = r_valid;
  assign bus.num_bits    = r_num_bits;
  assign bus.exhausted   = r_exhausted;

endmodule

// File: tb/tb_guess_generator.sv
// Directed bench for guess_generator with MAX_CHARS=2: word table, handshake timing,
// backpressure, async reset, enable drop and full enumeration to exhaustion.
module tb_guess_generator;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  guess_generator_if bus();

  guess_generator #(.MAX_CHARS(2), .CHARSET_SIZE(26), .FIRST_CHAR(8'h61)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  sp;
    logic [2:0]  inc;
    int          idx;
    logic [15:0] word;
    logic [7:0]  bits;
    string       name;
  } vec_t;

  vec_t vecs [16];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.guess_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: guess_valid got 0 required 1 (timeout)", name);
    end
  endtask

  task automatic restart(input logic [7:0] sp, input logic [2:0] inc);
    @(negedge clock);
    bus.enable   = 1'b0;
    bus.next_req = 1'b0;
    @(negedge clock);
    bus.start_position = sp;
    bus.increment      = inc;
    bus.enable         = 1'b1;
  endtask

  task automatic transfers(input string name, input int n);
    bit ok;
    for (int k = 0; k < n; k++) begin
      wait_valid(name, ok);
      if (!ok) return;
      bus.next_req = 1'b1;
      @(negedge clock);
      bus.next_req = 1'b0;
    end
  endtask

  function automatic logic [127:0] model_word(input int k);
    int m;
    if (k < 26) return {120'b0, 8'(97 + k)};
    m = k - 26;
    return {112'b0, 8'(97 + m / 26), 8'(97 + m % 26)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int k, last_v, ex_at;
    logic [127:0] w0;
    int stable;

    vecs[0]  = '{8'd0,  3'd1, 0,  16'h0061, 8'd8,  "seq_a"};
    vecs[1]  = '{8'd0,  3'd1, 25, 16'h007a, 8'd8,  "seq_z"};
    vecs[2]  = '{8'd0,  3'd1, 26, 16'h6161, 8'd16, "seq_aa"};
    vecs[3]  = '{8'd0,  3'd1, 27, 16'h6162, 8'd16, "seq_ab"};
    vecs[4]  = '{8'd0,  3'd1, 52, 16'h6261, 8'd16, "seq_ba"};
    vecs[5]  = '{8'd3,  3'd4, 0,  16'h0064, 8'd8,  "stride_d"};
    vecs[6]  = '{8'd3,  3'd4, 5,  16'h0078, 8'd8,  "stride_x"};
    vecs[7]  = '{8'd3,  3'd4, 6,  16'h6164, 8'd16, "stride_ad"};
    vecs[8]  = '{8'd3,  3'd4, 11, 16'h6178, 8'd16, "stride_ax"};
    vecs[9]  = '{8'd3,  3'd4, 12, 16'h6262, 8'd16, "stride_bb"};
    vecs[10] = '{8'd0,  3'd0, 1,  16'h0062, 8'd8,  "inc0_b"};
    vecs[11] = '{8'd0,  3'd0, 26, 16'h6161, 8'd16, "inc0_aa"};
    vecs[12] = '{8'd30, 3'd1, 0,  16'h0061, 8'd8,  "sp30_a"};
    vecs[13] = '{8'd30, 3'd1, 27, 16'h6162, 8'd16, "sp30_ab"};
    vecs[14] = '{8'd25, 3'd1, 1,  16'h617a, 8'd16, "sp25_az"};
    vecs[15] = '{8'd25, 3'd1, 2,  16'h6261, 8'd16, "sp25_ba"};

    reset = 1'b1;
    bus.enable = 1'b0;
    bus.next_req = 1'b0;
    bus.start_position = '0;
    bus.increment = 3'd1;
    #1;
    check("reset_guess", bus.guess, '0);
    check("reset_valid", 128'(bus.guess_valid), '0);
    check("reset_bits", 128'(bus.num_bits), '0);
    check("reset_exhausted", 128'(bus.exhausted), '0);
    #20;
    @(negedge clock);
    reset = 1'b0;

    for (int v = 0; v < 16; v++) begin
      restart(vecs[v].sp, vecs[v].inc);
      transfers(vecs[v].name, vecs[v].idx);
      wait_valid(vecs[v].name, ok);
      check({vecs[v].name, "_guess"}, bus.guess, {112'b0, vecs[v].word});
      check({vecs[v].name, "_bits"}, 128'(bus.num_bits), 128'(vecs[v].bits));
    end

    // Backpressure: 10 stalled cycles, one-cycle pulse, one-cycle gap, next word.
    restart(8'd0, 3'd1);
    wait_valid("bp_first", ok);
    w0 = bus.guess;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.guess_valid && bus.guess == w0) stable++;
    end
    check("bp_stable_cycles", 128'(stable), 128'(10));
    check("bp_word", w0, 128'h61);
    bus.next_req = 1'b1;
    @(negedge clock);
    bus.next_req = 1'b0;
    check("bp_gap_valid", 128'(bus.guess_valid), '0);
    @(negedge clock);
    check("bp_next_valid", 128'(bus.guess_valid), 128'(1));
    check("bp_next_word", bus.guess, 128'h62);

    // Enable drop with coincident next_req, then restart timing.
    restart(8'd0, 3'd1);
    transfers("en_drop", 3);
    wait_valid("en_drop", ok);
    check("en_drop_before", bus.guess, 128'h64);
    bus.enable = 1'b0;
    bus.next_req = 1'b1;
    @(negedge clock);
    check("en_drop_valid", 128'(bus.guess_valid), '0);
    check("en_drop_guess", bus.guess, '0);
    bus.next_req = 1'b0;
    bus.enable = 1'b1;
    @(negedge clock);
    check("en_load_valid", 128'(bus.guess_valid), '0);
    @(negedge clock);
    check("en_first_valid", 128'(bus.guess_valid), 128'(1));
    check("en_first_word", bus.guess, 128'h61);

    // Asynchronous reset mid-ADVANCE after 5 transfers.
    restart(8'd0, 3'd1);
    transfers("areset", 5);
    #2 reset = 1'b1;
    #1;
    check("areset_guess", bus.guess, '0);
    check("areset_valid", 128'(bus.guess_valid), '0);
    check("areset_bits", 128'(bus.num_bits), '0);
    @(negedge clock);
    reset = 1'b0;
    wait_valid("areset_restart", ok);
    check("areset_restart_word", bus.guess, 128'h61);

    // Full enumeration to exhaustion.
    restart(8'd0, 3'd1);
    bus.next_req = 1'b1;
    k = 0;
    last_v = -100;
    ex_at = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (bus.guess_valid) begin
        check($sformatf("enum_word_%0d", k), bus.guess, model_word(k));
        check($sformatf("enum_bits_%0d", k), 128'(bus.num_bits), (k < 26) ? 128'(8) : 128'(16));
        k++;
        last_v = c;
      end
      if (bus.exhausted) begin
        ex_at = c;
        break;
      end
    end
    check("enum_transfers", 128'(k), 128'(702));
    check("enum_exhaust_latency", 128'(ex_at - last_v), 128'(2));
    repeat (3) @(negedge clock);
    check("done_exhausted_hold", 128'(bus.exhausted), 128'(1));
    check("done_valid_low", 128'(bus.guess_valid), '0);
    bus.enable = 1'b0;
    bus.next_req = 1'b0;
    @(negedge clock);
    check("done_cleared", 128'(bus.exhausted), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
